// File: rtl/ceespu_console_pkg.sv
// Shared types and constants for the ceespu text console writer.
package ceespu_console_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_TEXT   = 3'd1,
        ST_COLOUR = 3'd2,
        ST_ESC    = 3'd3,
        ST_CLEAR  = 3'd4
    } console_state_e;

    localparam logic [7:0]  CODE_CR = 8'h0D;
    localparam logic [7:0]  CODE_LF = 8'h0A;
    localparam logic [7:0]  CODE_BS = 8'h08;
    localparam logic [7:0]  CODE_FF = 8'h0C;
    localparam logic [7:0]  CODE_ESC = 8'h1B;

    localparam logic [31:0] SPACE_WORD = 32'h2020_2020;

    localparam logic [24:0] TEXT_BASE_ADDR   = 25'h000F800;
    localparam logic [24:0] COLOUR_BASE_ADDR = 25'h000F000;

    function automatic logic [3:0] lane_strobe(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

    function automatic logic [24:0] word_addr(input logic [24:0] base, input logic [10:0] index);
        return base + {14'd0, index[10:2], 2'b00};
    endfunction

endpackage

// File: rtl/ceespu_console_cursor.sv
// Cursor position tracker: column/row with advance, newline, carriage return,
// backspace and home; flags the last column and the last (wrapping) row.
module ceespu_console_cursor #(
    parameter int COLS = 80,
    parameter int ROWS = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    input  logic       newline,
    input  logic       carriage,
    input  logic       backspace,
    input  logic       home,
    output logic [6:0] col,
    output logic [4:0] row,
    output logic       last_col,
    output logic       wrap
);

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    logic [6:0] col_r;
    logic [4:0] row_r;

    assign col      = col_r;
    assign row      = row_r;
    assign last_col = (col_r == LAST_COL);
    assign wrap     = (row_r == LAST_ROW);

    // Cursor update; a row advance from the last row wraps to row 0.
    always_ff @(posedge clk) begin
        if (reset || home) begin
            col_r <= 7'd0;
            row_r <= 5'd0;
        end else if (newline) begin
            col_r <= 7'd0;
            row_r <= wrap ? 5'd0 : row_r + 5'd1;
        end else if (carriage) begin
            col_r <= 7'd0;
        end else if (backspace) begin
            col_r <= (col_r != 7'd0) ? col_r - 7'd1 : col_r;
        end else if (advance) begin
            if (last_col) begin
                col_r <= 7'd0;
                row_r <= wrap ? 5'd0 : row_r + 5'd1;
            end else begin
                col_r <= col_r + 7'd1;
            end
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

endmodule

// File: rtl/ceespu_text_console.sv
// Text-console writer: byte stream in, byte-lane writes to the GPU text RAM out.
// Define CEESPU_CONSOLE_COLOUR_EN to add the attribute register and colour RAM writes.
module ceespu_text_console
    import ceespu_console_pkg::*;
#(
    parameter int          COLS      = 80,
    parameter int          ROWS      = 25,
    parameter logic [24:0] TEXT_BASE = TEXT_BASE_ADDR
`ifdef CEESPU_CONSOLE_COLOUR_EN
    ,
    parameter logic [24:0] COLOUR_BASE  = COLOUR_BASE_ADDR,
    parameter logic [7:0]  DEFAULT_ATTR = 8'h0F
`endif
) (
    input  logic        I_sys_clk,
    input  logic        I_sys_reset,
    input  logic        I_char_valid,
    input  logic [7:0]  I_char,
    output logic        O_char_ready,
    output logic [3:0]  O_sys_write_enable,
    output logic [24:0] O_sys_address,
    output logic [31:0] O_sys_data,
    input  logic        I_sys_ready,
    output logic [6:0]  O_cursor_col,
    output logic [4:0]  O_cursor_row
);

    localparam logic [9:0] CLR_ROW_LAST  = 10'(COLS / 4 - 1);
    localparam logic [9:0] CLR_FULL_LAST = 10'(COLS * ROWS / 4 - 1);

    console_state_e state_r;
    logic        ready_r;
    logic [3:0]  we_r;
    logic [24:0] addr_r;
    logic [31:0] data_r;
    logic [9:0]  clr_cnt_r;
    logic        clr_full_r;
`ifdef CEESPU_CONSOLE_COLOUR_EN
    logic [7:0]  attr_r;
    logic        clr_colour_r;
`endif

    logic [6:0]  col_s;
    logic [4:0]  row_s;
    logic        last_col_s;
    logic        wrap_s;
    logic [10:0] index_s;
    logic        accept_s;
    logic        ack_s;
    logic        clr_last_s;
    logic        glyph_wrap_s;
    logic        cur_adv_s;
    logic        cur_lf_s;
    logic        cur_cr_s;
    logic        cur_bs_s;
    logic        cur_home_s;

    ceespu_console_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
        .clk       (I_sys_clk),
        .reset     (I_sys_reset),
        .advance   (cur_adv_s),
        .newline   (cur_lf_s),
        .carriage  (cur_cr_s),
        .backspace (cur_bs_s),
        .home      (cur_home_s),
        .col       (col_s),
        .row       (row_s),
        .last_col  (last_col_s),
        .wrap      (wrap_s)
    );

    assign index_s      = 11'(row_s) * 11'(COLS) + 11'(col_s);
    assign accept_s     = I_char_valid & ready_r;
    assign ack_s        = I_sys_ready & (we_r != 4'd0);
    assign clr_last_s   = (clr_cnt_r == (clr_full_r ? CLR_FULL_LAST : CLR_ROW_LAST));
    assign glyph_wrap_s = last_col_s & wrap_s;

    assign O_char_ready       = ready_r & ~I_sys_reset;
    assign O_sys_write_enable = we_r;
    assign O_sys_address      = addr_r;
    assign O_sys_data         = data_r;
    assign O_cursor_col       = col_s;
    assign O_cursor_row       = row_s;

    // Cursor strobes: control codes act on acceptance, glyphs once their last write lands.
    always_comb begin
        cur_adv_s  = 1'b0;
        cur_lf_s   = 1'b0;
        cur_cr_s   = 1'b0;
        cur_bs_s   = 1'b0;
        cur_home_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    case (I_char)
                        CODE_CR: cur_cr_s   = 1'b1;
                        CODE_LF: cur_lf_s   = 1'b1;
                        CODE_BS: cur_bs_s   = 1'b1;
                        CODE_FF: cur_home_s = 1'b1;
                        default: cur_adv_s  = 1'b0;
                    endcase
                end else begin
                    cur_adv_s = 1'b0;
                end
            end
`ifdef CEESPU_CONSOLE_COLOUR_EN
            ST_COLOUR: begin
                if (ack_s) cur_adv_s = 1'b1;
                else       cur_adv_s = 1'b0;
            end
`else
            ST_TEXT: begin
                if (ack_s) cur_adv_s = 1'b1;
                else       cur_adv_s = 1'b0;
            end
`endif
            default: cur_adv_s = 1'b0;
        endcase
    end

    // Main FSM and registered bus driver; one request is outstanding at a time.
    always_ff @(posedge I_sys_clk) begin
        if (I_sys_reset) begin
            state_r    <= ST_IDLE;
            ready_r    <= 1'b1;
            we_r       <= 4'd0;
            addr_r     <= 25'd0;
            data_r     <= 32'd0;
            clr_cnt_r  <= 10'd0;
            clr_full_r <= 1'b0;
`ifdef CEESPU_CONSOLE_COLOUR_EN
            attr_r       <= DEFAULT_ATTR;
            clr_colour_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        case (I_char)
                            CODE_CR, CODE_BS: state_r <= ST_IDLE;
                            CODE_LF: begin
                                if (wrap_s) begin
                                    state_r    <= ST_CLEAR;
                                    ready_r    <= 1'b0;
                                    we_r       <= 4'hF;
                                    addr_r     <= TEXT_BASE;
                                    data_r     <= SPACE_WORD;
                                    clr_cnt_r  <= 10'd0;
                                    clr_full_r <= 1'b0;
`ifdef CEESPU_CONSOLE_COLOUR_EN
                                    clr_colour_r <= 1'b0;
`endif
                                end else begin
                                    state_r <= ST_IDLE;
                                end
                            end
                            CODE_FF: begin
                                state_r    <= ST_CLEAR;
                                ready_r    <= 1'b0;
                                we_r       <= 4'hF;
                                addr_r     <= TEXT_BASE;
                                data_r     <= SPACE_WORD;
                                clr_cnt_r  <= 10'd0;
                                clr_full_r <= 1'b1;
`ifdef CEESPU_CONSOLE_COLOUR_EN
                                clr_colour_r <= 1'b0;
`endif
                            end
`ifdef CEESPU_CONSOLE_COLOUR_EN
                            CODE_ESC: state_r <= ST_ESC;
`endif
                            default: begin
                                state_r <= ST_TEXT;
                                ready_r <= 1'b0;
                                we_r    <= lane_strobe(index_s[1:0]);
                                addr_r  <= word_addr(TEXT_BASE, index_s);
                                data_r  <= {4{I_char}};
                            end
                        endcase
                    end
                end
`ifdef CEESPU_CONSOLE_COLOUR_EN
                ST_ESC: begin
                    if (accept_s) begin
                        attr_r  <= I_char;
                        state_r <= ST_IDLE;
                    end
                end
                ST_TEXT: begin
                    if (ack_s) begin
                        state_r <= ST_COLOUR;
                        we_r    <= lane_strobe(index_s[1:0]);
                        addr_r  <= word_addr(COLOUR_BASE, index_s);
                        data_r  <= {4{attr_r}};
                    end
                end
                ST_COLOUR: begin
`else
                ST_TEXT: begin
`endif
                    if (ack_s) begin
                        if (glyph_wrap_s) begin
                            state_r    <= ST_CLEAR;
                            we_r       <= 4'hF;
                            addr_r     <= TEXT_BASE;
                            data_r     <= SPACE_WORD;
                            clr_cnt_r  <= 10'd0;
                            clr_full_r <= 1'b0;
`ifdef CEESPU_CONSOLE_COLOUR_EN
                            clr_colour_r <= 1'b0;
`endif
                        end else begin
                            state_r <= ST_IDLE;
                            ready_r <= 1'b1;
                            we_r    <= 4'd0;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (ack_s) begin
`ifdef CEESPU_CONSOLE_COLOUR_EN
                        // Each text word is followed by its colour word at the same offset.
                        if (!clr_colour_r) begin
                            clr_colour_r <= 1'b1;
                            addr_r       <= COLOUR_BASE + {13'd0, clr_cnt_r, 2'b00};
                            data_r       <= {4{attr_r}};
                        end else if (clr_last_s) begin
`else
                        if (clr_last_s) begin
`endif
                            state_r <= ST_IDLE;
                            ready_r <= 1'b1;
                            we_r    <= 4'd0;
                        end else begin
                            clr_cnt_r <= clr_cnt_r + 10'd1;
                            addr_r    <= TEXT_BASE + {13'd0, clr_cnt_r + 10'd1, 2'b00};
                            data_r    <= SPACE_WORD;
`ifdef CEESPU_CONSOLE_COLOUR_EN
                            clr_colour_r <= 1'b0;
`endif
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                    we_r    <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ceespu_text_console.sv
// Self-checking bench for ceespu_text_console (default build, colour disabled):
// directed latency/boundary cases plus randomized bytes against a cursor/write model.
module tb_ceespu_text_console;

    localparam int COLS = 80;
    localparam int ROWS = 25;

    typedef struct packed {
        logic [3:0]  we;
        logic [24:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        char_valid = 1'b0;
    logic [7:0]  char_byte = 8'h00;
    logic        char_ready;
    logic [3:0]  sys_we;
    logic [24:0] sys_addr;
    logic [31:0] sys_data;
    logic        sys_ready = 1'b1;
    logic [6:0]  cur_col;
    logic [4:0]  cur_row;

    int  n_checks = 0;
    int  n_fail = 0;
    int  bus_mode = 0;   // 0 always ready, 1 random stalls, 2 never ready
    int  wr_cycles = 0;
    int  m_col = 0;
    int  m_row = 0;
    bit  held = 1'b0;
    wr_t held_word;
    wr_t got_q[$];
    wr_t exp_q[$];

    ceespu_text_console dut (
        .I_sys_clk          (clk),
        .I_sys_reset        (rst),
        .I_char_valid       (char_valid),
        .I_char             (char_byte),
        .O_char_ready       (char_ready),
        .O_sys_write_enable (sys_we),
        .O_sys_address      (sys_addr),
        .O_sys_data         (sys_data),
        .I_sys_ready        (sys_ready),
        .O_cursor_col       (cur_col),
        .O_cursor_row       (cur_row)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus responder and write monitor: decides ready each cycle, logs accepted writes.
    initial begin
        bit r;
        forever begin
            @(negedge clk);
            if (held && !rst)
                check("hold", 64'({sys_we, sys_addr, sys_data}), 64'(held_word));
            case (bus_mode)
                0:       r = 1'b1;
                1:       r = ($urandom_range(0, 3) != 0);
                default: r = 1'b0;
            endcase
            sys_ready = r;
            if (sys_we != 4'd0) wr_cycles++;
            if (sys_we != 4'd0 && r) got_q.push_back({sys_we, sys_addr, sys_data});
            held      = (sys_we != 4'd0) && !r;
            held_word = {sys_we, sys_addr, sys_data};
        end
    end

    task automatic exp_clear(input int n);
        wr_t w;
        for (int k = 0; k < n; k++) begin
            w.we   = 4'hF;
            w.addr = 25'h000F800 + 25'(4 * k);
            w.data = 32'h2020_2020;
            exp_q.push_back(w);
        end
    endtask

    // Reference behaviour of one consumed byte: cursor arithmetic and expected writes.
    task automatic model_byte(input logic [7:0] b);
        int  idx;
        wr_t w;
        case (b)
            8'h0D: m_col = 0;
            8'h0A: begin
                m_col = 0;
                if (m_row == ROWS - 1) begin
                    m_row = 0;
                    exp_clear(COLS / 4);
                end else begin
                    m_row++;
                end
            end
            8'h08: if (m_col > 0) m_col--;
            8'h0C: begin
                exp_clear(COLS * ROWS / 4);
                m_col = 0;
                m_row = 0;
            end
            default: begin
                idx    = m_row * COLS + m_col;
                w.we   = 4'(1 << (idx % 4));
                w.addr = 25'h000F800 + 25'((idx / 4) * 4);
                w.data = {4{b}};
                exp_q.push_back(w);
                m_col++;
                if (m_col == COLS) begin
                    m_col = 0;
                    m_row++;
                    if (m_row == ROWS) begin
                        m_row = 0;
                        exp_clear(COLS / 4);
                    end
                end
            end
        endcase
    endtask

    task automatic check_writes();
        int n;
        check("wr_count", 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check("wr", 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_cursor(input string tag);
        check({tag, "_col"}, 64'(cur_col), 64'(m_col));
        check({tag, "_row"}, 64'(cur_row), 64'(m_row));
    endtask

    // Called at a negedge; returns at a negedge once the console is ready again.
    task automatic send_byte(input logic [7:0] b);
        int t;
        char_valid = 1'b1;
        char_byte  = b;
        t = 0;
        while (!char_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("accept_timeout", 64'(t < 100), 64'd1);
        @(negedge clk);
        char_valid = 1'b0;
        model_byte(b);
        t = 0;
        while (!char_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("idle_timeout", 64'(t < 5000), 64'd1);
        check_writes();
        check_cursor("cur");
    endtask

    task automatic reset_release();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 64'(char_ready), 64'd1);
        m_col = 0;
        m_row = 0;
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] b;
        int r;

        // Reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(char_ready), 64'd0);
        check("rst_we", 64'(sys_we), 64'd0);
        check("rst_addr", 64'(sys_addr), 64'd0);
        check("rst_data", 64'(sys_data), 64'd0);
        check_cursor("rst");
        reset_release();

        // 'A' latency: write visible at N+1, ready at N+2, cursor moves with the write
        bus_mode   = 0;
        char_valid = 1'b1;
        char_byte  = 8'h41;
        @(negedge clk);
        char_valid = 1'b0;
        model_byte(8'h41);
        check("lat_we", 64'(sys_we), 64'h1);
        check("lat_addr", 64'(sys_addr), 64'h0F800);
        check("lat_data", 64'(sys_data), 64'h41414141);
        check("lat_busy", 64'(char_ready), 64'd0);
        check("lat_col_hold", 64'(cur_col), 64'd0);
        @(negedge clk);
        check("lat_ready", 64'(char_ready), 64'd1);
        check("lat_we_off", 64'(sys_we), 64'd0);
        check_cursor("lat");
        check_writes();

        // CR: no write, ready straight away
        char_valid = 1'b1;
        char_byte  = 8'h0D;
        @(negedge clk);
        char_valid = 1'b0;
        model_byte(8'h0D);
        check("cr_ready", 64'(char_ready), 64'd1);
        check("cr_we", 64'(sys_we), 64'd0);
        check_cursor("cr");
        check_writes();

        // HELLO with random bus stalls
        rst = 1'b1;
        @(negedge clk);
        reset_release();
        bus_mode = 1;
        send_byte(8'h48);
        send_byte(8'h45);
        send_byte(8'h4C);
        send_byte(8'h4C);
        send_byte(8'h4F);

        // Full-screen clear with an always-ready bus
        bus_mode  = 0;
        wr_cycles = 0;
        send_byte(8'h0C);
        check("ff_cycles", 64'(wr_cycles), 64'd500);

        // 80 glyphs then 'X' at index 80, then two backspaces
        bus_mode = 1;
        for (int i = 0; i < COLS; i++) send_byte(8'($urandom_range(33, 126)));
        send_byte(8'h58);
        send_byte(8'h08);
        send_byte(8'h08);

        // LF down to the last row, then LF wraps and clears row 0
        for (int i = 0; i < ROWS - 2; i++) send_byte(8'h0A);
        check("row_last", 64'(cur_row), 64'd24);
        send_byte(8'h0A);

        // Glyph in the last cell wraps and clears row 0
        for (int i = 0; i < ROWS - 1; i++) send_byte(8'h0A);
        for (int i = 0; i < COLS; i++) send_byte(8'($urandom_range(33, 126)));

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 5)       b = 8'h0D;
            else if (r < 14) b = 8'h0A;
            else if (r < 19) b = 8'h08;
            else if (r < 21) b = 8'h0C;
            else             b = 8'($urandom_range(0, 255));
            send_byte(b);
        end

        // Reset while a write is stalled: request dropped at once
        bus_mode   = 2;
        char_valid = 1'b1;
        char_byte  = 8'h5A;
        @(negedge clk);
        char_valid = 1'b0;
        check("mw_pending", 64'(sys_we != 4'd0), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mw_we", 64'(sys_we), 64'd0);
        check("mw_ready", 64'(char_ready), 64'd0);
        bus_mode = 0;
        reset_release();
        check_cursor("mw");
        check_writes();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
